tft_spi_tx: RTL
===============

Name: tft_spi_tx

Overview:
Byte-level SPI transmitter at the display end of the TFT byte interface that all drawing blocks (player, maze, background) drive.
- Accepts one byte per `tft_transmit` pulse with its `tft_dc` flag and reports `tft_busy`.
- Serialises the byte MSB-first in SPI mode 0 onto the panel pins (SCK, MOSI, CS_N, DC).
- Keeps CS_N asserted across closely spaced bytes so command/parameter/pixel streams are not chopped.

Parameters:
- `DIV`, default 2: `clk` cycles per SCK half-period; legal values ≥1.
- `CS_HOLD`, default 8: idle `clk` cycles CS_N stays low after a byte before release; legal values ≥1.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset (0 = reset).
- `tft_transmit` in 1: one-cycle request; byte is valid this cycle.
- `tft_dc` in 1: 0 = command byte, 1 = data byte.
- `tft_data` in 8: byte to send.
- `tft_busy` out 1: high while a byte is being shifted.
- `spi_sck` out 1: serial clock, idle low.
- `spi_mosi` out 1: serial data.
- `spi_cs_n` out 1: chip select, active low.
- `spi_dc` out 1: data/command line to panel.

Behaviour:
- Reset (`rst` = 0, asynchronous):
  - Outputs go immediately to `spi_sck` = 0, `spi_cs_n` = 1, `spi_mosi` = 0, `spi_dc` = 0, `tft_busy` = 0.
  - State → IDLE; counters cleared.
  - A byte in flight is abandoned; no partial completion after release.
- States: IDLE, LOW, HIGH, HOLD.
- Accept condition: `tft_transmit` = 1 and `tft_busy` = 0, sampled in IDLE or HOLD. In cycle T of acceptance:
  - `tft_data` and `tft_dc` are latched into the shift register and `spi_dc`.
  - `tft_busy` = 1 from T+1; `spi_cs_n` = 0 from T+1.
  - `spi_mosi` = bit 7 from T+1.
  - State → LOW, bit counter = 7.
- LOW phase:
  - Lasts DIV cycles with `spi_sck` = 0 and `spi_mosi` stable.
  - Then → HIGH.
- HIGH phase:
  - Lasts DIV cycles with `spi_sck` = 1; the panel samples on the rising edge.
  - At its end, `spi_sck` returns to 0.
  - If bit counter > 0: decrement, shift so `spi_mosi` presents the next lower bit, → LOW.
  - If bit counter = 0: → HOLD, `tft_busy` = 0.
- Byte timing: `tft_busy` is high for exactly 16·DIV cycles (T+1 .. T+16·DIV).
- HOLD:
  - `spi_cs_n` stays 0, `spi_sck` = 0, `spi_mosi` holds the last bit.
  - An accepted request restarts at LOW exactly as from IDLE; `spi_cs_n` never pulses high between the bytes.
  - Otherwise, after CS_HOLD cycles in HOLD: `spi_cs_n` = 1, → IDLE.
  - A request in the same cycle the hold counter expires is accepted; CS stays low.
- `tft_transmit` while `tft_busy` = 1 is ignored: no latch, no queue, no error flag. Upstream senders wait on `~tft_busy & ~tft_transmit`.
- `tft_transmit` held high for multiple cycles counts as a single request at the first accepting cycle. It is re-accepted only after the next completed byte.
- `spi_dc` changes only on acceptance; it is constant for the whole byte.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Phase counter width is `$clog2(DIV)` with a minimum of 1. Hold counter width is `$clog2(CS_HOLD+1)`.

Decomposition:
- Shared package `tft_pkg`: state enum (IDLE/LOW/HIGH/HOLD) and command constants `CMD_CASET` = 8'h2a, `CMD_RASET` = 8'h2b, `CMD_RAMWR` = 8'h2c, reused by all drawing blocks.
- No sub-module: phase divider, bit counter and hold counter live inline in one module.

Test Plan:
- Send command byte (DIV=2): after reset release, pulse `tft_transmit` with `tft_dc` = 0, `tft_data` = 8'h2a.
  - `tft_busy` high for 32 cycles starting next cycle; `spi_cs_n` falls the same cycle.
  - 8 rising SCK edges sample 0,0,1,0,1,0,1,0; `spi_dc` = 0 throughout.
- Back-to-back stream: send 8'h2a (dc=0), then within 3 cycles of `tft_busy` falling send 8'h00 (dc=1), then 8'h05 (dc=1).
  - `spi_cs_n` stays low continuously; `spi_dc` switches to 1 before the second byte's first SCK edge.
  - 24 SCK rising edges total.
- Request while busy: pulse `tft_transmit` with 8'hff mid-byte of 8'h81.
  - Serial output is exactly 1,0,0,0,0,0,0,1; no ninth byte follows; `tft_busy` falls on schedule.
- CS release (CS_HOLD=4): send one byte, then stay idle.
  - `spi_cs_n` rises exactly 4 cycles after `tft_busy` falls.
  - A request on the 4th HOLD cycle instead keeps `spi_cs_n` low.
- Reset mid-byte: assert `rst` = 0 after 3 bits of 8'hc3.
  - Same cycle: `spi_sck` = 0, `spi_cs_n` = 1, `tft_busy` = 0.
  - After release, 8'h81 shifts completely and correctly.
- Max rate (DIV=1): send 8'ha5.
  - `spi_sck` toggles every cycle; `tft_busy` high for exactly 16 cycles.
  - Sampled bits 1,0,1,0,0,1,0,1.

Source files
------------

// File: rtl/tft_pkg.sv
// Shared TFT byte-interface definitions: transmitter state encoding and the
// panel command bytes reused by the player, maze and background drawing blocks.
package tft_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    HOLD
  } tft_state_t;

  localparam logic [7:0] CMD_CASET = 8'h2a;
  localparam logic [7:0] CMD_RASET = 8'h2b;
  localparam logic [7:0] CMD_RAMWR = 8'h2c;

endpackage

// File: rtl/tft_spi_tx_if.sv
// Byte handshake between a drawing block (master) and the SPI transmitter (slave).
interface tft_spi_tx_if;

  logic       tft_transmit;
  logic       tft_dc;
  logic [7:0] tft_data;
  logic       tft_busy;

  modport master (
    output tft_transmit,
    output tft_dc,
    output tft_data,
    input  tft_busy
  );

  modport slave (
    input  tft_transmit,
    input  tft_dc,
    input  tft_data,
    output tft_busy
  );

endinterface

// File: rtl/tft_spi_tx.sv
// Mode-0 SPI byte transmitter for the TFT panel; keeps CS_N low across
// closely spaced bytes so command/parameter/pixel streams stay contiguous.
module tft_spi_tx
  import tft_pkg::*;
#(
  parameter int DIV     = 2,
  parameter int CS_HOLD = 8
) (
  input  logic         clk,
  input  logic         rst,
  tft_spi_tx_if.slave  bus,
  output logic         spi_sck,
  output logic         spi_mosi,
  output logic         spi_cs_n,
  output logic         spi_dc
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int HW = $clog2(CS_HOLD + 1);
  localparam logic [PW-1:0] PH_LAST   = PW'(DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(CS_HOLD - 1);

  tft_state_t    state;
  logic [PW-1:0] phase_cnt;
  logic [2:0]    bit_cnt;
  logic [HW-1:0] hold_cnt;
  logic [6:0]    shift_reg;
  logic          busy_q;
  logic          accept;

  assign bus.tft_busy = busy_q;
  assign accept = bus.tft_transmit && !busy_q && (state == IDLE || state == HOLD);

  // Bit 7 goes straight to MOSI on acceptance, so the shifter only keeps the lower seven bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      phase_cnt <= '0;
      bit_cnt   <= '0;
      hold_cnt  <= '0;
      shift_reg <= '0;
      busy_q    <= 1'b0;
      spi_sck   <= 1'b0;
      spi_mosi  <= 1'b0;
      spi_cs_n  <= 1'b1;
      spi_dc    <= 1'b0;
    end else if (accept) begin
      state     <= LOW;
      phase_cnt <= '0;
      bit_cnt   <= 3'd7;
      hold_cnt  <= '0;
      shift_reg <= bus.tft_data[6:0];
      spi_mosi  <= bus.tft_data[7];
      spi_dc    <= bus.tft_dc;
      busy_q    <= 1'b1;
      spi_cs_n  <= 1'b0;
      spi_sck   <= 1'b0;
    end else begin
      case (state)
        LOW: begin
          if (phase_cnt == PH_LAST) begin
            phase_cnt <= '0;
            spi_sck   <= 1'b1;
            state     <= HIGH;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        HIGH: begin
          if (phase_cnt == PH_LAST) begin
            phase_cnt <= '0;
            spi_sck   <= 1'b0;
            if (bit_cnt != 3'd0) begin
              bit_cnt   <= bit_cnt - 3'd1;
              spi_mosi  <= shift_reg[6];
              shift_reg <= {shift_reg[5:0], 1'b0};
              state     <= LOW;
            end else begin
              busy_q   <= 1'b0;
              hold_cnt <= '0;
              state    <= HOLD;
            end
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            spi_cs_n <= 1'b1;
            state    <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
